// File: rtl/m68k_bus_pkg.sv
// Shared types and constants for the TG68K / DMA memory bus arbiter.
package m68k_bus_pkg;

    // Upper bound for ADDR_W; the latched request carries this many address bits.
    localparam int BUS_ADDR_W = 32;

    localparam logic [2:0] FC_DMA = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        CPU_CYC,
        DMA_CYC,
        CPU_DONE,
        DMA_DONE
    } arb_state_t;

    typedef enum logic {
        MASTER_CPU,
        MASTER_DMA
    } master_t;

    typedef struct packed {
        logic [BUS_ADDR_W-1:0] addr;
        logic [2:0]            fc;
        logic                  we;
        logic [1:0]            be;
        logic [15:0]           wdata;
    } bus_req_t;

endpackage

// File: rtl/m68k_bus_arbiter_if.sv
// Memory-side bus of the arbiter: the arbiter is the master, the memory fabric the slave.
interface m68k_bus_arbiter_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [2:0]        mem_fc;
    logic              mem_we;
    logic [1:0]        mem_be;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req, mem_addr, mem_fc, mem_we, mem_be, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_addr, mem_fc, mem_we, mem_be, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/m68k_bus_arbiter_timeout_ctr.sv
// Cycle counter that flags a memory cycle which has waited TIMEOUT_CYCLES-1 cycles without an ack.
module bus_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic nReset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Saturates at LAST so a stalled cycle can never wrap back to zero.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/m68k_bus_arbiter.sv
// Round-robin arbiter sharing one 16-bit memory bus between the TG68K CPU and a DMA requester.
module m68k_bus_arbiter
    import m68k_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              nReset,

    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [2:0]        cpu_fc,
    input  logic [15:0]       cpu_wdata,
    input  logic              cpu_uds,
    input  logic              cpu_lds,
    input  logic              cpu_write,
    output logic              cpu_clk_en,
    output logic [15:0]       cpu_rdata,
    output logic              cpu_berr,

    input  logic              dma_req,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [15:0]       dma_wdata,
    input  logic [1:0]        dma_be,
    input  logic              dma_write,
    output logic              dma_done,
    output logic [15:0]       dma_rdata,
    output logic              dma_err,

    m68k_bus_arbiter_if.master mem
);
    arb_state_t  state;
    arb_state_t  state_nxt;
    master_t     last_grant;
    bus_req_t    req_q;
    logic        mem_req_q;
    logic [15:0] cpu_rdata_q;
    logic [15:0] dma_rdata_q;
    logic        err_q;

    logic grant_cpu;
    logic grant_dma;
    logic no_strobe;
    logic in_cyc;
    logic ctr_clear;
    logic ctr_enable;
    logic tmo_expired;

    // A tie goes to whichever master did not win the previous grant.
    assign grant_cpu = (state == IDLE) && cpu_req && (!dma_req || last_grant == MASTER_DMA);
    assign grant_dma = (state == IDLE) && dma_req && !grant_cpu;
    assign no_strobe = cpu_uds && cpu_lds;
    assign in_cyc    = (state == CPU_CYC) || (state == DMA_CYC);

    bus_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .nReset (nReset),
        .clear  (ctr_clear),
        .enable (ctr_enable),
        .expired(tmo_expired)
    );

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_cpu) begin
                    state_nxt = no_strobe ? CPU_DONE : CPU_CYC;
                end else if (grant_dma) begin
                    state_nxt = DMA_CYC;
                end
            end
            CPU_CYC:  if (mem.mem_ack || tmo_expired) state_nxt = CPU_DONE;
            DMA_CYC:  if (mem.mem_ack || tmo_expired) state_nxt = DMA_DONE;
            CPU_DONE: state_nxt = IDLE;
            DMA_DONE: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cpu_clk_en = !(cpu_req && state != CPU_DONE);
        cpu_berr   = (state == CPU_DONE) && err_q;
        dma_done   = (state == DMA_DONE);
        dma_err    = (state == DMA_DONE) && err_q;
        ctr_clear  = grant_cpu || grant_dma;
        ctr_enable = in_cyc;
    end

    // Request latch and completion data; an ack beats a simultaneous timeout.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            last_grant  <= MASTER_DMA;
            req_q       <= '0;
            mem_req_q   <= 1'b0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_cpu) begin
                        last_grant <= MASTER_CPU;
                        req_q      <= '{addr:  BUS_ADDR_W'(cpu_addr),
                                        fc:    cpu_fc,
                                        we:    cpu_write,
                                        be:    ~{cpu_uds, cpu_lds},
                                        wdata: cpu_wdata};
                        err_q      <= 1'b0;
                        if (no_strobe) begin
                            cpu_rdata_q <= 16'hFFFF;
                        end else begin
                            mem_req_q <= 1'b1;
                        end
                    end else if (grant_dma) begin
                        last_grant <= MASTER_DMA;
                        req_q      <= '{addr:  BUS_ADDR_W'(dma_addr),
                                        fc:    FC_DMA,
                                        we:    dma_write,
                                        be:    dma_be,
                                        wdata: dma_wdata};
                        err_q      <= 1'b0;
                        mem_req_q  <= 1'b1;
                    end
                end
                CPU_CYC, DMA_CYC: begin
                    if (mem.mem_ack) begin
                        mem_req_q <= 1'b0;
                        err_q     <= 1'b0;
                        if (!req_q.we) begin
                            if (state == CPU_CYC) begin
                                cpu_rdata_q <= mem.mem_rdata;
                            end else begin
                                dma_rdata_q <= mem.mem_rdata;
                            end
                        end
                    end else if (tmo_expired) begin
                        mem_req_q <= 1'b0;
                        err_q     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cpu_rdata     = cpu_rdata_q;
    assign dma_rdata     = dma_rdata_q;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_addr  = req_q.addr[ADDR_W-1:0];
    assign mem.mem_fc    = req_q.fc;
    assign mem.mem_we    = req_q.we;
    assign mem.mem_be    = req_q.be;
    assign mem.mem_wdata = req_q.wdata;

endmodule
